// File: rtl/cache_hierarchy_types.sv
// Shared types for the victim cache controller.
//   vc_t        : one victim-cache entry (line-aligned address + 256-bit line)
//   vc_state_t  : controller FSM states
//   line_addr() : clears the byte-offset bits of an address
package cache_hierarchy_types;

    typedef struct packed {
        logic [31:0]  address;
        logic [255:0] data;
    } vc_t;

    typedef enum logic [2:0] {
        VC_IDLE,
        VC_RESP,
        VC_MISS_RD,
        VC_WB,
        VC_ALLOC
    } vc_state_t;

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

endpackage

// File: rtl/victim_lru.sv
// Age-counter LRU tracker for the victim cache.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (ages return to entry index)
//   touch      : mark touch_idx as most recently used this cycle
//   touch_idx  : entry being touched
//   lru_idx    : entry whose age is NUM_ENTRIES-1 (the eviction candidate)
module victim_lru
    import cache_hierarchy_types::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_idx,
    output logic [IDX_W-1:0] lru_idx
);

    logic [IDX_W-1:0] age_q [NUM_ENTRIES];

    // Entries younger than the touched one age by one; the touched one becomes 0.
    // This keeps the ages a permutation of 0..NUM_ENTRIES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else if (touch) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IDX_W'(i) == touch_idx) begin
                    age_q[i] <= '0;
                end else if (age_q[i] < age_q[touch_idx]) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (age_q[i] == IDX_W'(NUM_ENTRIES - 1)) begin
                lru_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Fully-associative victim cache controller between the last cache level and memory.
// Writebacks from above are absorbed into entries (all valid entries are dirty);
// read hits are served from entries, read misses go straight to memory without
// allocation. A dirty LRU entry is written to memory only when its slot is reused.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   mem_read/mem_write/mem_address/mem_wdata : upper-level request (held until mem_resp)
//   mem_rdata/mem_resp                    : upper-level read line and one-cycle completion
//   pmem_read/pmem_write/pmem_address/pmem_wdata : memory request (held until pmem_resp)
//   pmem_rdata/pmem_resp                  : memory read line and completion pulse
module victim_cache_ctrl
    import cache_hierarchy_types::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    vc_state_t            state_q, state_d;
    vc_t                  entries_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [IDX_W-1:0]     victim_q, victim_d;
    logic [255:0]         rdata_q;

    logic                 hit, has_free;
    logic [IDX_W-1:0]     hit_idx, free_idx, lru_idx;
    logic                 touch;
    logic [IDX_W-1:0]     touch_idx;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic                 load_hit, load_pmem;

    // Tag match on the line address; first matching valid entry wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && valid_q[i] &&
                entries_q[i].address[31:5] == mem_address[31:5]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index invalid slot.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!has_free && !valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    victim_lru #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .touch     (touch),
        .touch_idx (touch_idx),
        .lru_idx   (lru_idx)
    );

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        touch        = 1'b0;
        touch_idx    = hit_idx;
        wr_en        = 1'b0;
        wr_idx       = hit_idx;
        load_hit     = 1'b0;
        load_pmem    = 1'b0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        unique case (state_q)
            VC_IDLE: begin
                if (mem_write) begin
                    if (hit) begin
                        wr_en   = 1'b1;
                        touch   = 1'b1;
                        state_d = VC_RESP;
                    end else if (has_free) begin
                        wr_en     = 1'b1;
                        wr_idx    = free_idx;
                        touch     = 1'b1;
                        touch_idx = free_idx;
                        state_d   = VC_RESP;
                    end else begin
                        victim_d = lru_idx;
                        state_d  = VC_WB;
                    end
                end else if (mem_read) begin
                    if (hit) begin
                        load_hit = 1'b1;
                        touch    = 1'b1;
                        state_d  = VC_RESP;
                    end else begin
                        state_d = VC_MISS_RD;
                    end
                end
            end
            VC_WB: begin
                pmem_write   = 1'b1;
                pmem_address = entries_q[victim_q].address;
                pmem_wdata   = entries_q[victim_q].data;
                if (pmem_resp) begin
                    state_d = VC_ALLOC;
                end
            end
            VC_ALLOC: begin
                wr_en     = 1'b1;
                wr_idx    = victim_q;
                touch     = 1'b1;
                touch_idx = victim_q;
                state_d   = VC_RESP;
            end
            VC_MISS_RD: begin
                pmem_read    = 1'b1;
                pmem_address = line_addr(mem_address);
                if (pmem_resp) begin
                    load_pmem = 1'b1;
                    state_d   = VC_RESP;
                end
            end
            VC_RESP: begin
                mem_resp = 1'b1;
                state_d  = VC_IDLE;
            end
            default: state_d = VC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= VC_IDLE;
            victim_q <= '0;
            valid_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
            end
            if (load_hit) begin
                rdata_q <= entries_q[hit_idx].data;
            end else if (load_pmem) begin
                rdata_q <= pmem_rdata;
            end
        end
    end

    // Line storage carries no reset; only valid bits qualify it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries_q[wr_idx] <= '{address: line_addr(mem_address), data: mem_wdata};
        end
    end

    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
module tb_victim_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    localparam logic [255:0] A  = {8{32'hAAAA_0001}};
    localparam logic [255:0] A2 = {8{32'hAAAA_0002}};
    localparam logic [255:0] B  = {8{32'hBBBB_0001}};
    localparam logic [255:0] C  = {8{32'hCCCC_0001}};
    localparam logic [255:0] E  = {8{32'hEEEE_0001}};

    victim_cache_ctrl #(.NUM_ENTRIES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input int k);
        return {8{32'(k) ^ 32'h5A5A_0000}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drop the request and confirm mem_resp was a single-cycle pulse.
    task automatic finish_txn(input string tag);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        check({tag, "_pulse"}, {255'b0, mem_resp}, 256'd0);
    endtask

    // Wait for mem_resp; cyc = edges after the request was driven (-1 on timeout).
    task automatic wait_resp(output int cyc, output bit saw_pmem);
        cyc      = -1;
        saw_pmem = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (pmem_read || pmem_write) saw_pmem = 1'b1;
            if (mem_resp) begin
                cyc = n;
                break;
            end
        end
    endtask

    // Request that must complete locally: the request cycle plus the RESP
    // cycle, i.e. mem_resp seen one edge after the request is driven.
    task automatic local_txn(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [255:0] wdata, input bit chk_data,
                             input logic [255:0] exp_rdata, input string tag);
        int cyc;
        bit saw;
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = wdata;
        wait_resp(cyc, saw);
        check({tag, "_lat"}, 256'(cyc), 256'd1);
        check({tag, "_pmem_quiet"}, {255'b0, saw}, 256'd0);
        if (chk_data) check({tag, "_rdata"}, mem_rdata, exp_rdata);
        finish_txn(tag);
    endtask

    // Memory model: wait for a strobe, verify it, stall one cycle, then respond.
    task automatic pmem_serve(input bit exp_wr, input logic [31:0] exp_addr,
                              input logic [255:0] exp_wdata, input logic [255:0] rdata,
                              input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (pmem_read || pmem_write) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_pmem_seen"}, {255'b0, seen}, 256'd1);
        check({tag, "_pmem_wr"}, {255'b0, pmem_write}, {255'b0, exp_wr});
        check({tag, "_pmem_rd"}, {255'b0, pmem_read}, {255'b0, !exp_wr});
        check({tag, "_pmem_addr"}, 256'(pmem_address), 256'(exp_addr));
        if (exp_wr) check({tag, "_pmem_wdata"}, pmem_wdata, exp_wdata);
        @(posedge clk); #1;
        check({tag, "_pmem_hold"}, {255'b0, pmem_read | pmem_write}, 256'd1);
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  saw;
        bit  seen;

        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_resp", {255'b0, mem_resp}, 256'd0);
        check("rst_pmem_strobes", {254'b0, pmem_read, pmem_write}, 256'd0);
        check("rst_mem_rdata", mem_rdata, 256'd0);
        check("rst_pmem_addr", 256'(pmem_address), 256'd0);
        check("rst_pmem_wdata", pmem_wdata, 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: read miss goes to memory, no allocation
        mem_read = 1'b1; mem_address = 32'h0000_1000;
        pmem_serve(1'b0, 32'h0000_1000, '0, A, "t1_miss");
        check("t1_resp", {255'b0, mem_resp}, 256'd1);
        check("t1_rdata", mem_rdata, A);
        finish_txn("t1");
        mem_read = 1'b1; mem_address = 32'h0000_1000;
        pmem_serve(1'b0, 32'h0000_1000, '0, A2, "t1_remiss");
        check("t1_rdata2", mem_rdata, A2);
        finish_txn("t1b");

        // 2: write absorbed locally, then a read hit on another offset of the line
        local_txn(1'b0, 1'b1, 32'h0000_1000, B, 1'b0, '0, "t2_wr");
        local_txn(1'b1, 1'b0, 32'h0000_1004, '0, 1'b1, B, "t2_rd");

        // 3: fill all four slots, then evict the LRU (0x1000)
        local_txn(1'b0, 1'b1, 32'h0000_1000, pat(1), 1'b0, '0, "t3_w1");
        local_txn(1'b0, 1'b1, 32'h0000_2000, pat(2), 1'b0, '0, "t3_w2");
        local_txn(1'b0, 1'b1, 32'h0000_3000, pat(3), 1'b0, '0, "t3_w3");
        local_txn(1'b0, 1'b1, 32'h0000_4000, pat(4), 1'b0, '0, "t3_w4");
        mem_write = 1'b1; mem_address = 32'h0000_5000; mem_wdata = pat(5);
        pmem_serve(1'b1, 32'h0000_1000, pat(1), '0, "t3_evict");
        wait_resp(cyc, saw);
        check("t3_alloc_lat", 256'(cyc), 256'd1);
        finish_txn("t3_evict");
        local_txn(1'b1, 1'b0, 32'h0000_5000, '0, 1'b1, pat(5), "t3_rd5");

        // 4: touching 0x2000 makes 0x3000 the victim
        local_txn(1'b1, 1'b0, 32'h0000_2000, '0, 1'b1, pat(2), "t4_rd2");
        mem_write = 1'b1; mem_address = 32'h0000_6000; mem_wdata = pat(6);
        pmem_serve(1'b1, 32'h0000_3000, pat(3), '0, "t4_evict");
        wait_resp(cyc, saw);
        check("t4_alloc_lat", 256'(cyc), 256'd1);
        finish_txn("t4_evict");

        // 5: simultaneous read and write is a write
        local_txn(1'b1, 1'b1, 32'h0000_2000, C, 1'b0, '0, "t5_both");
        local_txn(1'b1, 1'b0, 32'h0000_2000, '0, 1'b1, C, "t5_rd");

        // 6: reset while the eviction of 0x4000 is stalled in WB
        mem_write = 1'b1; mem_address = 32'h0000_7000; mem_wdata = pat(7);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (pmem_write) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_wb_seen", {255'b0, seen}, 256'd1);
        check("t6_wb_addr", 256'(pmem_address), 256'h4000);
        rst = 1'b1; mem_write = 1'b0;
        @(posedge clk); #1;
        check("t6_wr_drop", {255'b0, pmem_write}, 256'd0);
        check("t6_rd_low", {255'b0, pmem_read}, 256'd0);
        check("t6_addr_zero", 256'(pmem_address), 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = 32'h0000_2000;
        pmem_serve(1'b0, 32'h0000_2000, '0, E, "t6_miss");
        check("t6_rdata", mem_rdata, E);
        finish_txn("t6");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
